// File: rtl/vram_dma_controller_pkg.sv
// Shared definitions for the VRAM DMA sequencer: FSM states, register offsets,
// CTRL bit positions and the register-window decode helper.
package vram_dma_controller_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT_VB = 2'd1,
        ST_READ    = 2'd2,
        ST_WRITE   = 2'd3
    } dma_state_e;

    localparam logic [1:0] OFS_SRC  = 2'd0;
    localparam logic [1:0] OFS_DST  = 2'd1;
    localparam logic [1:0] OFS_LEN  = 2'd2;
    localparam logic [1:0] OFS_CTRL = 2'd3;

    localparam int CTRL_START   = 0;
    localparam int CTRL_WAIT_VB = 1;
    localparam int CTRL_ABORT   = 2;

    // True when addr falls inside the four-word register window starting at base.
    function automatic logic reg_hit(input logic [15:0] addr, input logic [15:0] base);
        logic [15:0] delta;
        delta = addr - base;
        return (delta < 16'd4);
    endfunction

endpackage

// File: rtl/vram_dma_controller_dma_regfile.sv
// DMA configuration registers: address decode, CPU writes and
// one-cycle registered readback that mimics RAM read latency.
module dma_regfile
    import vram_dma_controller_pkg::*;
#(
    parameter logic [15:0] DMA_BASE  = 16'h4804,
    parameter int          LEN_WIDTH = 13
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [15:0]          cpu_memaddr,
    input  logic                 cpu_memwrite,
    input  logic [15:0]          cpu_writedata,
    input  logic                 cfg_en,
    input  logic                 rd_en,
    input  logic                 busy,
    input  logic                 done,
    output logic [15:0]          src,
    output logic [15:0]          dst,
    output logic [LEN_WIDTH-1:0] len,
    output logic                 hit,
    output logic                 ctrl_wr,
    output logic                 rd_sel,
    output logic [15:0]          rd_data
);

    logic [15:0]          src_r;
    logic [15:0]          dst_r;
    logic [LEN_WIDTH-1:0] len_r;
    logic                 rd_sel_r;
    logic [15:0]          rd_data_r;
    logic [1:0]           ofs_s;
    logic [15:0]          rd_mux_s;

    assign hit     = reg_hit(cpu_memaddr, DMA_BASE);
    assign ofs_s   = 2'(cpu_memaddr - DMA_BASE);
    assign ctrl_wr = hit && cpu_memwrite && (ofs_s == OFS_CTRL);

    // Configuration writes are only accepted while the sequencer is idle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            src_r <= 16'h0000;
            dst_r <= 16'h0000;
            len_r <= '0;
        end else if (cfg_en && cpu_memwrite && hit) begin
            case (ofs_s)
                OFS_SRC: src_r <= cpu_writedata;
                OFS_DST: dst_r <= cpu_writedata;
                OFS_LEN: len_r <= cpu_writedata[LEN_WIDTH-1:0];
                default: ;
            endcase
        end
    end

    // Readback value selection for the addressed register.
    always_comb begin
        rd_mux_s = 16'h0000;
        case (ofs_s)
            OFS_SRC:  rd_mux_s = src_r;
            OFS_DST:  rd_mux_s = dst_r;
            OFS_LEN:  rd_mux_s[LEN_WIDTH-1:0] = len_r;
            OFS_CTRL: rd_mux_s = {14'b0, done, busy};
            default:  rd_mux_s = 16'h0000;
        endcase
    end

    // Register the readback so it lines up with the memory's read latency.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_sel_r  <= 1'b0;
            rd_data_r <= 16'h0000;
        end else begin
            rd_sel_r  <= hit && rd_en;
            rd_data_r <= rd_mux_s;
        end
    end

    assign src     = src_r;
    assign dst     = dst_r;
    assign len     = len_r;
    assign rd_sel  = rd_sel_r;
    assign rd_data = rd_data_r;

endmodule

// File: rtl/vram_dma_controller.sv
// Block-copy DMA sequencer on the CPU memory port; stalls the CPU while it
// owns the port and can defer copying until vertical blank.
module vram_dma_controller
    import vram_dma_controller_pkg::*;
#(
    parameter logic [15:0] DMA_BASE  = 16'h4804,
    parameter int          LEN_WIDTH = 13
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cpu_memaddr,
    input  logic        cpu_memwrite,
    input  logic [15:0] cpu_writedata,
    output logic [15:0] cpu_memdata,
    output logic        cpu_stall,
    output logic [15:0] mem_addr,
    output logic        mem_write,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        vbright,
    output logic        busy,
    output logic        done
);

    dma_state_e           state_r;
    dma_state_e           state_nx_s;
    logic [15:0]          src_ptr_r;
    logic [15:0]          dst_ptr_r;
    logic [LEN_WIDTH-1:0] count_r;
    logic                 wait_vb_r;
    logic                 done_r;

    logic [15:0]          src_s;
    logic [15:0]          dst_s;
    logic [LEN_WIDTH-1:0] len_s;
    logic                 hit_s;
    logic                 ctrl_wr_s;
    logic                 rd_sel_s;
    logic [15:0]          rd_data_s;
    logic                 start_s;
    logic                 abort_s;
    logic                 last_word_s;

    assign abort_s     = ctrl_wr_s && cpu_writedata[CTRL_ABORT];
    assign start_s     = ctrl_wr_s && cpu_writedata[CTRL_START] && !cpu_writedata[CTRL_ABORT];
    assign last_word_s = (count_r == LEN_WIDTH'(1));

    dma_regfile #(
        .DMA_BASE  (DMA_BASE),
        .LEN_WIDTH (LEN_WIDTH)
    ) u_regs (
        .clk           (clk),
        .rst           (rst),
        .cpu_memaddr   (cpu_memaddr),
        .cpu_memwrite  (cpu_memwrite),
        .cpu_writedata (cpu_writedata),
        .cfg_en        (state_r == ST_IDLE),
        .rd_en         (!cpu_stall),
        .busy          (busy),
        .done          (done_r),
        .src           (src_s),
        .dst           (dst_s),
        .len           (len_s),
        .hit           (hit_s),
        .ctrl_wr       (ctrl_wr_s),
        .rd_sel        (rd_sel_s),
        .rd_data       (rd_data_s)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_r <= ST_IDLE;
        else      state_r <= state_nx_s;
    end

    // Next-state logic; a word in flight always finishes before pausing.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_s && (len_s != '0))
                    state_nx_s = cpu_writedata[CTRL_WAIT_VB] ? ST_WAIT_VB : ST_READ;
                else
                    state_nx_s = ST_IDLE;
            end
            ST_WAIT_VB: begin
                if (abort_s)       state_nx_s = ST_IDLE;
                else if (!vbright) state_nx_s = ST_READ;
                else               state_nx_s = ST_WAIT_VB;
            end
            ST_READ: state_nx_s = ST_WRITE;
            ST_WRITE: begin
                if (last_word_s)               state_nx_s = ST_IDLE;
                else if (wait_vb_r && vbright) state_nx_s = ST_WAIT_VB;
                else                           state_nx_s = ST_READ;
            end
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // Transfer pointers, remaining count and sticky completion flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            src_ptr_r <= 16'h0000;
            dst_ptr_r <= 16'h0000;
            count_r   <= '0;
            wait_vb_r <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start_s) begin
                        src_ptr_r <= src_s;
                        dst_ptr_r <= dst_s;
                        count_r   <= len_s;
                        wait_vb_r <= cpu_writedata[CTRL_WAIT_VB];
                        done_r    <= (len_s == '0);
                    end
                end
                ST_WRITE: begin
                    src_ptr_r <= src_ptr_r + 16'd1;
                    dst_ptr_r <= dst_ptr_r + 16'd1;
                    count_r   <= count_r - LEN_WIDTH'(1);
                    if (last_word_s) done_r <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Memory port ownership: CPU pass-through except while copying a word.
    always_comb begin
        mem_addr  = cpu_memaddr;
        mem_wdata = cpu_writedata;
        mem_write = cpu_memwrite && !hit_s;
        cpu_stall = 1'b0;
        case (state_r)
            ST_READ: begin
                mem_addr  = src_ptr_r;
                mem_write = 1'b0;
                cpu_stall = 1'b1;
            end
            ST_WRITE: begin
                mem_addr  = dst_ptr_r;
                mem_wdata = mem_rdata;
                mem_write = 1'b1;
                cpu_stall = 1'b1;
            end
            default: ;
        endcase
    end

    assign cpu_memdata = rd_sel_s ? rd_data_s : mem_rdata;
    assign busy        = (state_r != ST_IDLE);
    assign done        = done_r;

endmodule

// File: tb/tb_vram_dma_controller.sv
// Directed bench for vram_dma_controller with a RAM model behind the decoder
// port and a scoreboard of expected memory writes and register readbacks.
module tb_vram_dma_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] cpu_memaddr = 16'h0000;
    logic        cpu_memwrite = 1'b0;
    logic [15:0] cpu_writedata = 16'h0000;
    logic [15:0] cpu_memdata;
    logic        cpu_stall;
    logic [15:0] mem_addr;
    logic        mem_write;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        vbright = 1'b0;
    logic        busy;
    logic        done;

    logic [15:0] ram [0:65535];
    logic [31:0] exp_q[$];
    logic [31:0] obs_q[$];
    logic [15:0] rd_q[$];
    int          stall_cnt = 0;
    int          n_tests = 0;
    int          n_fail = 0;
    int          s0;

    vram_dma_controller dut (
        .clk           (clk),
        .rst           (rst),
        .cpu_memaddr   (cpu_memaddr),
        .cpu_memwrite  (cpu_memwrite),
        .cpu_writedata (cpu_writedata),
        .cpu_memdata   (cpu_memdata),
        .cpu_stall     (cpu_stall),
        .mem_addr      (mem_addr),
        .mem_write     (mem_write),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata),
        .vbright       (vbright),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;

    // Synchronous RAM: one-cycle read latency, write on strobe.
    always @(posedge clk) begin
        if (mem_write) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    // Monitor mid-cycle: record every write reaching memory and count stall cycles.
    always @(negedge clk) begin
        if (rst && mem_write) obs_q.push_back({mem_addr, mem_wdata});
        if (cpu_stall) stall_cnt++;
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cpu_write(input logic [15:0] a, input logic [15:0] d, input bit to_mem);
        step();
        cpu_memaddr   = a;
        cpu_writedata = d;
        cpu_memwrite  = 1'b1;
        if (to_mem) exp_q.push_back({a, d});
        step();
        cpu_memwrite  = 1'b0;
    endtask

    task automatic cpu_read(input string tag, input logic [15:0] a, input logic [15:0] exp);
        step();
        cpu_memaddr  = a;
        cpu_memwrite = 1'b0;
        rd_q.push_back(exp);
        step();
        check(tag, {16'h0000, cpu_memdata}, {16'h0000, rd_q.pop_front()});
    endtask

    task automatic check_writes(input string tag);
        check({tag, "_nwr"}, 32'(obs_q.size()), 32'(exp_q.size()));
        while (obs_q.size() > 0 && exp_q.size() > 0)
            check({tag, "_wr"}, obs_q.pop_front(), exp_q.pop_front());
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic wait_idle(input string tag, input int max_cycles);
        int n;
        n = 0;
        while (busy === 1'b1 && n < max_cycles) begin
            step();
            n++;
        end
        check({tag, "_idle"}, {31'b0, busy}, 32'd0);
    endtask

    task automatic setup(input logic [15:0] src, input logic [15:0] dst, input logic [15:0] len);
        cpu_write(16'h4804, src, 1'b0);
        cpu_write(16'h4805, dst, 1'b0);
        cpu_write(16'h4806, len, 1'b0);
    endtask

    initial begin
        // Reset state
        #12;
        check("rst_busy",  {31'b0, busy},      32'd0);
        check("rst_done",  {31'b0, done},      32'd0);
        check("rst_stall", {31'b0, cpu_stall}, 32'd0);
        check("rst_mwr",   {31'b0, mem_write}, 32'd0);
        rst = 1'b1;
        step();

        // Source data is loaded through the CPU pass-through path
        for (int i = 0; i < 4; i++) cpu_write(16'h0100 + 16'(i), 16'hA000 + 16'(i), 1'b1);
        for (int i = 0; i < 5; i++) cpu_write(16'h0200 + 16'(i), 16'hB000 + 16'(i), 1'b1);
        for (int i = 0; i < 3; i++) cpu_write(16'h0300 + 16'(i), 16'hC000 + 16'(i), 1'b1);
        cpu_write(16'hFFFF, 16'hBEEF, 1'b1);
        cpu_write(16'h0000, 16'hCAFE, 1'b1);
        check_writes("preload");
        cpu_read("ram_rd", 16'h0102, 16'hA002);

        // Reset in the middle of a transfer
        setup(16'h0100, 16'h2000, 16'd4);
        cpu_write(16'h4807, 16'h0001, 1'b0);
        for (int i = 0; i < 20 && mem_write !== 1'b1; i++) step();
        check("mid_in_write", {31'b0, mem_write}, 32'd1);
        rst = 1'b0;
        #1;
        check("mid_busy",  {31'b0, busy},      32'd0);
        check("mid_done",  {31'b0, done},      32'd0);
        check("mid_stall", {31'b0, cpu_stall}, 32'd0);
        step();
        rst = 1'b1;
        obs_q.delete();
        cpu_read("mid_src",  16'h4804, 16'h0000);
        cpu_read("mid_dst",  16'h4805, 16'h0000);
        cpu_read("mid_len",  16'h4806, 16'h0000);
        cpu_read("mid_ctrl", 16'h4807, 16'h0000);

        // Plain 4-word copy during vertical blank
        vbright = 1'b0;
        setup(16'h0100, 16'h2000, 16'd4);
        for (int i = 0; i < 4; i++) exp_q.push_back({16'h2000 + 16'(i), 16'hA000 + 16'(i)});
        s0 = stall_cnt;
        cpu_write(16'h4807, 16'h0001, 1'b0);
        wait_idle("copy4", 40);
        check("copy4_stalls", 32'(stall_cnt - s0), 32'd8);
        check("copy4_done", {31'b0, done}, 32'd1);
        check_writes("copy4");
        cpu_read("copy4_ctrl", 16'h4807, 16'h0002);
        cpu_read("copy4_ram",  16'h2003, 16'hA003);

        // Zero-length start completes at once
        cpu_write(16'h4806, 16'h0000, 1'b0);
        s0 = stall_cnt;
        cpu_write(16'h4807, 16'h0001, 1'b0);
        check("len0_done", {31'b0, done}, 32'd1);
        check("len0_busy", {31'b0, busy}, 32'd0);
        step();
        step();
        check("len0_stalls", 32'(stall_cnt - s0), 32'd0);
        check_writes("len0");

        // Wait for vertical blank, pause when visible region re-entered
        vbright = 1'b1;
        setup(16'h0200, 16'h3000, 16'd5);
        for (int i = 0; i < 5; i++) exp_q.push_back({16'h3000 + 16'(i), 16'hB000 + 16'(i)});
        s0 = stall_cnt;
        cpu_write(16'h4807, 16'h0003, 1'b0);
        cpu_read("wvb_cpu_runs", 16'h0201, 16'hB001);
        step();
        check("wvb_busy",   {31'b0, busy}, 32'd1);
        check("wvb_nostall", 32'(stall_cnt - s0), 32'd0);
        vbright = 1'b0;
        for (int i = 0; i < 6; i++) step();
        vbright = 1'b1;
        step();
        step();
        step();
        check("wvb_pause_busy",  {31'b0, busy}, 32'd1);
        check("wvb_pause_stall", {31'b0, cpu_stall}, 32'd0);
        check("wvb_pause_stalls", 32'(stall_cnt - s0), 32'd6);
        check("wvb_pause_nwr", 32'(obs_q.size()), 32'd3);
        check("wvb_pause_count", 32'(dut.count_r), 32'd2);
        vbright = 1'b0;
        wait_idle("wvb", 40);
        check("wvb_stalls", 32'(stall_cnt - s0), 32'd10);
        check("wvb_done", {31'b0, done}, 32'd1);
        check_writes("wvb");

        // Abort while waiting; configuration writes ignored while busy
        vbright = 1'b1;
        setup(16'h0300, 16'h3100, 16'd3);
        cpu_write(16'h4807, 16'h0003, 1'b0);
        cpu_write(16'h4804, 16'h1234, 1'b0);
        cpu_write(16'h4807, 16'h0004, 1'b0);
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_done", {31'b0, done}, 32'd0);
        cpu_read("abort_src", 16'h4804, 16'h0300);
        check_writes("abort");

        // Source pointer wraps from 0xFFFF to 0x0000; register writes never reach memory
        vbright = 1'b0;
        setup(16'hFFFF, 16'h3200, 16'd2);
        exp_q.push_back({16'h3200, 16'hBEEF});
        exp_q.push_back({16'h3201, 16'hCAFE});
        cpu_write(16'h4807, 16'h0001, 1'b0);
        wait_idle("wrap", 20);
        check_writes("wrap");
        cpu_write(16'h4806, 16'h0003, 1'b0);
        cpu_write(16'h0050, 16'h5A5A, 1'b1);
        check_writes("regwr_mask");
        cpu_read("wrap_len", 16'h4806, 16'h0003);
        cpu_read("wrap_ram", 16'h3201, 16'hCAFE);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
